// File: rtl/mpu_bus_bridge.sv
// Bridges a multiplexed-address/data MPU bus onto a single-clock word-wide request bus.
// MPU strobes are synchronized; writes may be staged into whole words, reads may hit a shadow word.
module mpu_bus_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_BYTES  = 2,
    parameter int WORD_MODE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             _reset,
    input  logic                             mpu_ale,
    input  logic                             _mpu_rd,
    input  logic                             _mpu_wr,
    input  logic [ADDR_WIDTH-DATA_WIDTH-1:0] mpu_ah,
    inout  wire  [DATA_WIDTH-1:0]            mpu_ad,
    output logic [ADDR_WIDTH-1:0]            bus_addr,
    output logic                             bus_wr_en,
    output logic                             bus_rd_en,
    output logic [WORD_BYTES-1:0]            bus_be,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] bus_wdata,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] bus_rdata,
    output logic                             bus_err
);
    localparam int LANE_BITS = (WORD_BYTES == 4) ? 2 : ((WORD_BYTES == 2) ? 1 : 0);
    localparam int LW        = (LANE_BITS == 0) ? 1 : LANE_BITS;
    localparam int WW        = DATA_WIDTH * WORD_BYTES;
    localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE     = 3'd1;
    localparam logic [2:0] READ_REQ  = 3'd2;
    localparam logic [2:0] READ_WAIT = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;

    logic [2:0]             state;
    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic                   rd_prev, wr_prev;
    logic                   rd_s, wr_s;
    logic                   rd_assert, wr_assert, wr_deassert, conflict;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_aligned;
    logic [DATA_WIDTH-1:0]  wdata_q, rd_byte;
    logic [LW-1:0]          addr_lane, rd_lane_q;
    logic [WW-1:0]          stage_q, shadow_q, merged;
    logic                   fetch_q, wr_armed, need_fetch;

    assign rd_s        = rd_sync[SYNC_STAGES-1];
    assign wr_s        = wr_sync[SYNC_STAGES-1];
    assign rd_assert   = rd_prev & ~rd_s;
    assign wr_assert   = wr_prev & ~wr_s;
    assign wr_deassert = ~wr_prev & wr_s;
    assign conflict    = ~rd_s & ~wr_s;

    assign addr_lane    = addr_q[LW-1:0] & LAST_LANE;
    assign addr_aligned = addr_q & ~ADDR_WIDTH'(WORD_BYTES - 1);
    assign need_fetch   = (WORD_MODE == 0) || (addr_lane == '0);
    assign rd_byte      = shadow_q[rd_lane_q*DATA_WIDTH +: DATA_WIDTH];

    // The pad is only driven once the captured byte is ready and the MPU is actively reading.
    assign mpu_ad = (!_mpu_rd && !mpu_ale && state == HOLD) ? rd_byte : {DATA_WIDTH{1'bz}};

    always_comb begin
        merged = stage_q;
        merged[addr_lane*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rd_sync <= '1;
            wr_sync <= '1;
            rd_prev <= 1'b1;
            wr_prev <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], _mpu_rd};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], _mpu_wr};
            rd_prev <= rd_s;
            wr_prev <= wr_s;
            if (mpu_ale)
                addr_q <= {mpu_ah, mpu_ad};
            if (!_mpu_wr && !mpu_ale)
                wdata_q <= mpu_ad;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state     <= IDLE;
            bus_addr  <= '0;
            bus_wr_en <= 1'b0;
            bus_rd_en <= 1'b0;
            bus_be    <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            stage_q   <= '0;
            shadow_q  <= '0;
            rd_lane_q <= '0;
            fetch_q   <= 1'b0;
            wr_armed  <= 1'b0;
        end else begin
            bus_wr_en <= 1'b0;
            bus_rd_en <= 1'b0;
            // A write is only honoured on release if its assertion was seen cleanly in IDLE/WRITE.
            if (conflict) begin
                state    <= IDLE;
                bus_err  <= 1'b1;
                wr_armed <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_assert)
                            wr_armed <= 1'b1;
                        if (rd_assert) begin
                            state     <= READ_REQ;
                            rd_lane_q <= addr_lane;
                            fetch_q   <= need_fetch;
                            bus_rd_en <= need_fetch;
                            if (need_fetch)
                                bus_addr <= addr_aligned;
                        end else if (wr_deassert && wr_armed) begin
                            state    <= WRITE;
                            wr_armed <= 1'b0;
                            if (WORD_MODE == 0) begin
                                bus_wr_en <= 1'b1;
                                bus_addr  <= addr_aligned;
                                bus_be    <= WORD_BYTES'(1) << addr_lane;
                                bus_wdata <= {WORD_BYTES{wdata_q}};
                            end else if (addr_lane == LAST_LANE) begin
                                bus_wr_en <= 1'b1;
                                bus_addr  <= addr_aligned;
                                bus_be    <= '1;
                                bus_wdata <= merged;
                            end else begin
                                stage_q <= merged;
                            end
                        end
                    end
                    WRITE: begin
                        state <= IDLE;
                        if (wr_assert)
                            wr_armed <= 1'b1;
                    end
                    READ_REQ: begin
                        state <= READ_WAIT;
                        if (wr_assert)
                            bus_err <= 1'b1;
                    end
                    READ_WAIT: begin
                        state <= HOLD;
                        if (fetch_q)
                            shadow_q <= bus_rdata;
                        if (wr_assert)
                            bus_err <= 1'b1;
                    end
                    HOLD: begin
                        if (rd_s)
                            state <= IDLE;
                        if (wr_assert)
                            bus_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mpu_bus_bridge.sv
// Scoreboard bench for mpu_bus_bridge: a word-staging instance (u0) and a byte-passthrough instance (u1).
`timescale 1ns/1ps
module tb_mpu_bus_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        _reset, mpu_ale, wr_n, rd_n, sel, tb_drv, rd_en_d;
    logic [7:0]  mpu_ah, tb_ad;
    logic [15:0] rd_word, bus_rdata0, bus_rdata1;
    tri1  [7:0]  mpu_ad;
    logic        wr0, wr1;

    logic [15:0] bus_addr0, bus_addr1, bus_wdata0, bus_wdata1;
    logic        bus_wr_en0, bus_wr_en1, bus_rd_en0, bus_rd_en1, bus_err0, bus_err1;
    logic [1:0]  bus_be0, bus_be1;

    assign mpu_ad = tb_drv ? tb_ad : 8'hzz;
    assign wr0    = sel ? 1'b1 : wr_n;
    assign wr1    = sel ? wr_n : 1'b1;

    mpu_bus_bridge #(.WORD_MODE(1)) u0 (
        .clk(clk), ._reset(_reset), .mpu_ale(mpu_ale), ._mpu_rd(rd_n), ._mpu_wr(wr0),
        .mpu_ah(mpu_ah), .mpu_ad(mpu_ad), .bus_addr(bus_addr0), .bus_wr_en(bus_wr_en0),
        .bus_rd_en(bus_rd_en0), .bus_be(bus_be0), .bus_wdata(bus_wdata0),
        .bus_rdata(bus_rdata0), .bus_err(bus_err0)
    );

    mpu_bus_bridge #(.WORD_MODE(0)) u1 (
        .clk(clk), ._reset(_reset), .mpu_ale(mpu_ale), ._mpu_rd(1'b1), ._mpu_wr(wr1),
        .mpu_ah(mpu_ah), .mpu_ad(mpu_ad), .bus_addr(bus_addr1), .bus_wr_en(bus_wr_en1),
        .bus_rd_en(bus_rd_en1), .bus_be(bus_be1), .bus_wdata(bus_wdata1),
        .bus_rdata(bus_rdata1), .bus_err(bus_err1)
    );

    typedef struct packed {
        logic        dev;
        logic        is_wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
    } txn_t;

    txn_t       bus_q[$];
    logic [7:0] rd_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic exp_bus(input logic dev, input logic is_wr, input logic [15:0] a,
                           input logic [1:0] be, input logic [15:0] d);
        txn_t t;
        t.dev = dev; t.is_wr = is_wr; t.addr = a; t.be = be; t.data = d;
        bus_q.push_back(t);
    endtask

    task automatic bus_obs(input logic dev, input logic wr, input logic rd, input logic [15:0] a,
                           input logic [1:0] be, input logic [15:0] d);
        txn_t t;
        if (bus_q.size() == 0) begin
            chk("unexpected_bus_pulse", {dev, wr, rd}, 32'h0);
        end else begin
            t = bus_q.pop_front();
            chk("bus_dev", dev, t.dev);
            chk("bus_wr_en", wr, t.is_wr);
            chk("bus_rd_en", rd, !t.is_wr);
            chk("bus_addr", a, t.addr);
            if (t.is_wr) begin
                chk("bus_be", be, t.be);
                chk("bus_wdata", d, t.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus_wr_en0 || bus_rd_en0)
            bus_obs(1'b0, bus_wr_en0, bus_rd_en0, bus_addr0, bus_be0, bus_wdata0);
        if (bus_wr_en1 || bus_rd_en1)
            bus_obs(1'b1, bus_wr_en1, bus_rd_en1, bus_addr1, bus_be1, bus_wdata1);
    end

    // Memory model: read data is presented only in the cycle after the request pulse.
    always @(posedge clk) begin
        #1;
        bus_rdata0 = rd_en_d ? rd_word : 16'h5a5a;
        rd_en_d    = bus_rd_en0;
    end

    task automatic mpu_addr(input logic [15:0] a);
        @(posedge clk); #1;
        mpu_ah  = a[15:8];
        tb_ad   = a[7:0];
        tb_drv  = 1'b1;
        mpu_ale = 1'b1;
        @(posedge clk); #1;
        mpu_ale = 1'b0;
        tb_drv  = 1'b0;
    endtask

    task automatic mpu_write(input logic [15:0] a, input logic [7:0] d);
        mpu_addr(a);
        tb_ad  = d;
        tb_drv = 1'b1;
        wr_n   = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        wr_n   = 1'b1;
        tb_drv = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic mpu_read(input logic [15:0] a);
        logic [7:0] exp;
        mpu_addr(a);
        rd_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rd_not_early", mpu_ad, 8'hff);
        @(posedge clk); #1;
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
        chk("mpu_rd_data", mpu_ad, exp);
        @(posedge clk); #1;
        rd_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rd_released", mpu_ad, 8'hff);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        _reset = 1'b0; mpu_ale = 1'b0; mpu_ah = '0; wr_n = 1'b1; rd_n = 1'b1; sel = 1'b0;
        tb_drv = 1'b0; tb_ad = '0; rd_word = '0; rd_en_d = 1'b0; bus_rdata0 = '0; bus_rdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", bus_wr_en0, 1'b0);
        chk("rst_rd_en", bus_rd_en0, 1'b0);
        chk("rst_err", bus_err0, 1'b0);
        chk("rst_addr", bus_addr0, 16'h0);
        chk("rst_be", bus_be0, 2'b00);
        chk("rst_wdata", bus_wdata0, 16'h0);
        chk("rst_ad_undriven", mpu_ad, 8'hff);
        chk("rst_u1_wr_en", bus_wr_en1, 1'b0);
        @(posedge clk); #1;
        _reset = 1'b1;
        repeat (2) @(posedge clk);

        // Word staging: lane 0 is held back, lane 1 completes the word.
        mpu_write(16'h0000, 8'had);
        exp_bus(1'b0, 1'b1, 16'h0000, 2'b11, 16'hdead);
        mpu_write(16'h0001, 8'hde);

        // Byte passthrough instance: one-hot lane, byte replicated.
        sel = 1'b1;
        exp_bus(1'b1, 1'b1, 16'h0002, 2'b10, 16'hffff);
        mpu_write(16'h0003, 8'hff);
        sel = 1'b0;

        // Latest staged byte wins; an unwritten lane keeps its previous staged value.
        mpu_write(16'h0010, 8'h11);
        mpu_write(16'h0010, 8'h22);
        exp_bus(1'b0, 1'b1, 16'h0010, 2'b11, 16'h3322);
        mpu_write(16'h0011, 8'h33);
        exp_bus(1'b0, 1'b1, 16'h0020, 2'b11, 16'h9922);
        mpu_write(16'h0021, 8'h99);

        // Lane 0 read fetches the word; lane 1 read is served from the shadow copy.
        rd_word = 16'hbeef;
        exp_bus(1'b0, 1'b0, 16'h1002, 2'b00, 16'h0);
        rd_q.push_back(8'hef);
        mpu_read(16'h1002);
        rd_word = 16'h0000;
        rd_q.push_back(8'hbe);
        mpu_read(16'h1003);

        // Address-only activity must neither drive the pad nor reach the bus.
        for (int i = 0; i < 4; i++) begin
            mpu_addr(16'($urandom_range(0, 65535)));
            repeat (3) begin
                @(negedge clk);
                chk("idle_ad_undriven", mpu_ad, 8'hff);
            end
        end
        chk("err_clear_before_conflict", bus_err0, 1'b0);

        // Both strobes together: no bus activity, sticky error.
        @(posedge clk); #1;
        wr_n = 1'b0;
        rd_n = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("conflict_ad_undriven", mpu_ad, 8'hff);
        end
        @(posedge clk); #1;
        wr_n = 1'b1;
        rd_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("conflict_err_set", bus_err0, 1'b1);
        mpu_addr(16'h5555);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("conflict_err_sticky", bus_err0, 1'b1);

        // Reset in the middle of a lane-1 write after lane 0 was staged.
        mpu_write(16'h3000, 8'h55);
        mpu_addr(16'h3001);
        tb_ad  = 8'h77;
        tb_drv = 1'b1;
        wr_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        _reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_err_clear", bus_err0, 1'b0);
        chk("mid_rst_wr_en", bus_wr_en0, 1'b0);
        @(posedge clk); #1;
        wr_n   = 1'b1;
        tb_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        _reset = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("post_rst_err", bus_err0, 1'b0);
        chk("post_rst_wdata", bus_wdata0, 16'h0);
        exp_bus(1'b0, 1'b1, 16'h3000, 2'b11, 16'h1200);
        mpu_write(16'h3001, 8'h12);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("final_u1_err", bus_err1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
